// File: rtl/rotr_pkg.sv
// Shared types and constants for the rotr_arbiter block: data/shift widths,
// request payload struct and the 1-bit requester id.
package rotr_pkg;

    localparam int DATA_W  = 16;
    localparam int SHIFT_W = 4;

    localparam logic [DATA_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHIFT_W-1:0] shift;
    } rotr_req_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } rotr_src_t;

endpackage

// File: rtl/rotr_arbiter_if.sv
// Handshake bundle between the two operand producers, the arbiter and the
// downstream consumer; slave is the arbiter's view, master the environment's.
interface rotr_arbiter_if;
    import rotr_pkg::*;

    logic                req0_valid;
    logic [DATA_W-1:0]   req0_data;
    logic [SHIFT_W-1:0]  req0_shift;
    logic                req0_ready;

    logic                req1_valid;
    logic [DATA_W-1:0]   req1_data;
    logic [SHIFT_W-1:0]  req1_shift;
    logic                req1_ready;

    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_src;
    logic                out_ready;

    modport slave (
        input  req0_valid, req0_data, req0_shift,
        input  req1_valid, req1_data, req1_shift,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_src
    );

    modport master (
        output req0_valid, req0_data, req0_shift,
        output req1_valid, req1_data, req1_shift,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_src
    );

endinterface

// File: rtl/rotr_arbiter_rotr16.sv
// rotr16: combinational 16-bit right rotator built as a four-stage log
// shifter (1, 2, 4, 8 bits), each stage feeding the next.
module rotr16
    import rotr_pkg::*;
(
    input  logic [DATA_W-1:0]  in,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  y
);

    logic [DATA_W-1:0] s1, s2, s4;

    always_comb begin
        s1 = shift[0] ? {in[0],    in[15:1]} : in;
        s2 = shift[1] ? {s1[1:0],  s1[15:2]} : s1;
        s4 = shift[2] ? {s2[3:0],  s2[15:4]} : s2;
        y  = shift[3] ? {s4[7:0],  s4[15:8]} : s4;
    end

endmodule

// File: rtl/rotr_arbiter.sv
// Round-robin arbiter sharing one right-rotate datapath between two requesters,
// with a one-entry registered output. ROTR_STATS_EN adds saturating grant counters.
module rotr_arbiter
    import rotr_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    rotr_arbiter_if.slave bus
`ifdef ROTR_STATS_EN
    ,
    output logic [DATA_W-1:0] grant_cnt0,
    output logic [DATA_W-1:0] grant_cnt1
`endif
);

    logic              free;
    logic              rdy0, rdy1, accept;
    rotr_src_t         winner;
    rotr_req_t         sel_req;
    logic [DATA_W-1:0] rot_y;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    rotr_src_t         out_src_q,   out_src_d;
    rotr_src_t         last_q,      last_d;

    // Ready depends only on valids, output occupancy and last, never on payload.
    always_comb begin
        free   = !out_valid_q || bus.out_ready;
        winner = SRC0;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = (last_q == SRC0) ? SRC1 : SRC0;
        end else if (bus.req1_valid) begin
            winner = SRC1;
        end
        rdy0   = free && bus.req0_valid && (winner == SRC0);
        rdy1   = free && bus.req1_valid && (winner == SRC1);
        accept = rdy0 || rdy1;

        sel_req.data  = bus.req0_data;
        sel_req.shift = bus.req0_shift;
        if (winner == SRC1) begin
            sel_req.data  = bus.req1_data;
            sel_req.shift = bus.req1_shift;
        end
    end

    rotr16 u_rotr16 (
        .in    (sel_req.data),
        .shift (sel_req.shift),
        .y     (rot_y)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = rot_y;
            out_src_d   = winner;
            last_d      = winner;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC0;
            last_q      <= SRC1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;

`ifdef ROTR_STATS_EN
    logic [DATA_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [DATA_W-1:0] grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (rdy0 && grant_cnt0_q != CNT_MAX) grant_cnt0_d = grant_cnt0_q + 1'b1;
        if (rdy1 && grant_cnt1_q != CNT_MAX) grant_cnt1_d = grant_cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_rotr_arbiter.sv
// Self-checking bench for rotr_arbiter: directed and random traffic against a
// behavioural model; grant counters are checked when ROTR_STATS_EN is defined.
module tb_rotr_arbiter;

    logic clk;
    logic rst_n;

    rotr_arbiter_if bus ();

`ifdef ROTR_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    rotr_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef ROTR_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    logic [15:0] r_in, r_y;
    logic [3:0]  r_sh;

    rotr16 u_rot_chk (
        .in    (r_in),
        .shift (r_sh),
        .y     (r_y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Requester / consumer drive state
    bit          a_v[2];
    logic [15:0] a_d[2];
    logic [3:0]  a_s[2];
    bit          a_ordy;

    // Reference model state
    bit          m_valid;
    logic [15:0] m_data;
    int          m_src;
    int          m_last;
    int          m_cnt[2];
    int          last_grant;

    function automatic logic [15:0] rot_ref(input logic [15:0] d, input int s);
        int x;
        x = int'(d);
        return 16'(((x >> s) | (x << (16 - s))) & 32'hFFFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_src    = 0;
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    // Pulses reset away from the clock edge and checks the asynchronous clear.
    task automatic do_reset(input bit keep_valid);
        if (!keep_valid) begin
            a_v[0] = 1'b0;
            a_v[1] = 1'b0;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_out_src",   bus.out_src,   0);
`ifdef ROTR_STATS_EN
        chk("rst_cnt0", grant_cnt0, 0);
        chk("rst_cnt1", grant_cnt1, 0);
`endif
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, check readys before the edge, check outputs after.
    task automatic step();
        int g;
        bit free;
        bus.req0_valid = a_v[0];
        bus.req0_data  = a_d[0];
        bus.req0_shift = a_s[0];
        bus.req1_valid = a_v[1];
        bus.req1_data  = a_d[1];
        bus.req1_shift = a_s[1];
        bus.out_ready  = a_ordy;
        #1;
        free = !m_valid || a_ordy;
        g = -1;
        if (a_v[0] && a_v[1]) g = 1 - m_last;
        else if (a_v[0])      g = 0;
        else if (a_v[1])      g = 1;
        if (!free) g = -1;
        chk("req0_ready", bus.req0_ready, (g == 0));
        chk("req1_ready", bus.req1_ready, (g == 1));
        @(posedge clk);
        #1;
        last_grant = g;
        if (g >= 0) begin
            m_data  = rot_ref(a_d[g], int'(a_s[g]));
            m_src   = g;
            m_valid = 1'b1;
            m_last  = g;
            if (m_cnt[g] != 32'hFFFF) m_cnt[g]++;
            a_v[g]  = 1'b0;
        end else if (m_valid && a_ordy) begin
            m_valid = 1'b0;
        end
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_data",  bus.out_data,  m_data);
        chk("out_src",   bus.out_src,   m_src);
`ifdef ROTR_STATS_EN
        chk("grant_cnt0", grant_cnt0, m_cnt[0]);
        chk("grant_cnt1", grant_cnt1, m_cnt[1]);
`endif
    endtask

    logic [15:0] t_d[5];
    logic [3:0]  t_s[5];
    logic [15:0] t_e[5];
    logic [15:0] vals[3];
    logic [15:0] hold_d;
    logic        hold_s;
    int          exp_g;

    initial begin
        rst_n  = 1'b1;
        a_v[0] = 1'b0;  a_v[1] = 1'b0;
        a_d[0] = '0;    a_d[1] = '0;
        a_s[0] = '0;    a_s[1] = '0;
        a_ordy = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_shift = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_shift = '0;
        bus.out_ready  = 1'b1;
        r_in = '0;
        r_sh = '0;
        model_reset();

        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Directed single rotations through requester 0
        t_d = '{16'h0001, 16'h1234, 16'hABCD, 16'h8001, 16'h5A5A};
        t_s = '{4'd1,     4'd4,     4'd8,     4'd15,    4'd0};
        t_e = '{16'h8000, 16'h4123, 16'hCDAB, 16'h0003, 16'h5A5A};
        a_ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_v[0] = 1'b1;
            a_d[0] = t_d[i];
            a_s[0] = t_s[i];
            step();
            chk("dir_rot_data", bus.out_data, t_e[i]);
            chk("dir_rot_src",  bus.out_src,  0);
        end
        step();

        // Rotator alone: every shift amount on three patterns
        vals = '{16'h0001, 16'h8421, 16'hF00D};
        for (int v = 0; v < 3; v++) begin
            for (int s = 0; s < 16; s++) begin
                r_in = vals[v];
                r_sh = 4'(s);
                #1;
                chk("rotr16", r_y, rot_ref(vals[v], s));
            end
        end
        r_in = 16'h1234;
        r_sh = 4'd12;
        #1;
        chk("rotr16_s12", r_y, 16'h2341);
        @(posedge clk);
        #1;

        // Both requesters continuously valid: grants alternate from requester 0
        do_reset(1'b0);
        a_ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 2; r++) begin
                a_v[r] = 1'b1;
                a_d[r] = 16'($urandom);
                a_s[r] = 4'($urandom);
            end
            step();
            chk("alt_src", bus.out_src, i % 2);
        end

        // Backpressure for three cycles with both valid
        hold_d = bus.out_data;
        hold_s = bus.out_src;
        a_v[0] = 1'b1;
        a_v[1] = 1'b1;
        a_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data", bus.out_data, hold_d);
            chk("bp_hold_src",  bus.out_src,  hold_s);
        end
        exp_g  = 1 - m_last;
        a_ordy = 1'b1;
        step();
        chk("bp_release_valid", bus.out_valid, 1);
        chk("bp_release_src",   bus.out_src,   exp_g);

        // Reset while a result is pending and requester 1 is still valid
        a_v[0] = 1'b0;
        a_v[1] = 1'b1;
        a_d[1] = 16'h00F0;
        a_s[1] = 4'd4;
        step();
        chk("pre_rst_data", bus.out_data, 16'h000F);
        a_v[1] = 1'b1;
        a_d[1] = 16'h0F00;
        bus.req1_valid = 1'b1;
        bus.req1_data  = a_d[1];
        do_reset(1'b1);
        a_v[0] = 1'b1;
        a_d[0] = 16'h0100;
        a_s[0] = 4'd8;
        step();
        chk("post_rst_src", bus.out_src, 0);
        chk("post_rst_grant", last_grant, 0);
        step();
        chk("post_rst_src2", bus.out_src, 1);

        // Random traffic with stable payload while waiting
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!a_v[r] && ($urandom_range(2) != 0)) begin
                    a_v[r] = 1'b1;
                    a_d[r] = 16'($urandom);
                    a_s[r] = 4'($urandom);
                end
            end
            a_ordy = ($urandom_range(3) != 0);
            step();
        end

`ifdef ROTR_STATS_EN
        // Grant counters: fixed counts, then saturation from a preloaded value
        a_ordy = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            a_v[i < 5 ? 0 : 1] = 1'b1;
            a_d[i < 5 ? 0 : 1] = 16'($urandom);
            a_s[i < 5 ? 0 : 1] = 4'($urandom);
            step();
        end
        chk("stats_cnt0_5", grant_cnt0, 5);
        chk("stats_cnt1_3", grant_cnt1, 3);
        force dut.grant_cnt0_q = 16'hFFFD;
        #1;
        release dut.grant_cnt0_q;
        m_cnt[0] = 32'hFFFD;
        for (int i = 0; i < 4; i++) begin
            a_v[0] = 1'b1;
            a_d[0] = 16'($urandom);
            step();
        end
        chk("stats_sat", grant_cnt0, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
